// File: rtl/data_mem.sv
// 256 x 8 single-port data memory: synchronous write, combinational read,
// synchronous active-low reset that clears the whole array.
module data_mem #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 8
) (
    input  logic          CLK,
    input  logic          ResetN,
    input  logic [AW-1:0] DataAddress,
    input  logic [1:0]    MemStatus,
    input  logic [DW-1:0] DataIn,
    output logic [DW-1:0] DataOut
);

    localparam int unsigned Depth = 1 << AW;

    typedef enum logic [1:0] {
        CmdIdle  = 2'b00,
        CmdRead  = 2'b01,
        CmdWrite = 2'b10,
        CmdRsvd  = 2'b11
    } mem_cmd_e;

    logic [DW-1:0] mem_q [Depth];
    logic          write_en;
    logic          read_en;

    // Exact-match decode: an unknown command evaluates false and never writes.
    always_comb begin
        write_en = 1'b0;
        read_en  = 1'b0;
        if (MemStatus == CmdWrite) begin
            write_en = 1'b1;
        end
        if (MemStatus == CmdRead) begin
            read_en = 1'b1;
        end
    end

    // Reset wins over a write on the same edge.
    always_ff @(posedge CLK) begin
        if (!ResetN) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_en) begin
            mem_q[DataAddress] <= DataIn;
        end
    end

    always_comb begin
        DataOut = '0;
        if (read_en) begin
            DataOut = mem_q[DataAddress];
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed vector table, a combinational
// address sweep, then randomized traffic against an array model.
module tb_data_mem;

    logic       CLK;
    logic       ResetN;
    logic [7:0] DataAddress;
    logic [1:0] MemStatus;
    logic [7:0] DataIn;
    logic [7:0] DataOut;

    int total = 0;
    int bad   = 0;

    data_mem #(
        .DW(8),
        .AW(8)
    ) dut (
        .CLK        (CLK),
        .ResetN     (ResetN),
        .DataAddress(DataAddress),
        .MemStatus  (MemStatus),
        .DataIn     (DataIn),
        .DataOut    (DataOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic       rst_n;
        logic [1:0] st;
        logic [7:0] addr;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] model [256];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic [1:0] st, input logic [7:0] addr,
                         input logic [7:0] din);
        ResetN      = rst_n;
        MemStatus   = st;
        DataAddress = addr;
        DataIn      = din;
    endtask

    // Apply inputs mid-cycle, check the combinational output, then take the edge.
    task automatic step(input vec_t v);
        drive(v.rst_n, v.st, v.addr, v.din);
        #2;
        check(v.name, DataOut, v.exp);
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(input string name, input logic rst_n, input logic [1:0] st,
                                input logic [7:0] addr, input logic [7:0] din,
                                input logic [7:0] exp);
        vec_t v;
        v.name  = name;
        v.rst_n = rst_n;
        v.st    = st;
        v.addr  = addr;
        v.din   = din;
        v.exp   = exp;
        return v;
    endfunction

    initial begin
        logic [1:0]  st;
        logic [7:0]  a;
        logic [7:0]  d;
        logic        r;
        logic [7:0]  exp;

        drive(1'b0, 2'b00, 8'h00, 8'h00);
        @(posedge CLK);
        #1;

        vecs.push_back(mk("reset_idle",      1'b0, 2'b00, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk("write_a0",        1'b1, 2'b10, 8'h00, 8'hFF, 8'h00));
        vecs.push_back(mk("read_a0",         1'b1, 2'b01, 8'h00, 8'h00, 8'hFF));
        vecs.push_back(mk("read_a1_empty",   1'b1, 2'b01, 8'h01, 8'h00, 8'h00));
        vecs.push_back(mk("idle_gated",      1'b1, 2'b00, 8'h00, 8'h77, 8'h00));
        vecs.push_back(mk("rsvd_gated",      1'b1, 2'b11, 8'h00, 8'h77, 8'h00));
        vecs.push_back(mk("a0_after_rsvd",   1'b1, 2'b01, 8'h00, 8'h00, 8'hFF));
        vecs.push_back(mk("write_a2",        1'b1, 2'b10, 8'h02, 8'h01, 8'h00));
        vecs.push_back(mk("read_a2",         1'b1, 2'b01, 8'h02, 8'h00, 8'h01));
        vecs.push_back(mk("write_a255",      1'b1, 2'b10, 8'hFF, 8'hA5, 8'h00));
        vecs.push_back(mk("read_a255",       1'b1, 2'b01, 8'hFF, 8'h00, 8'hA5));
        vecs.push_back(mk("a0_unchanged",    1'b1, 2'b01, 8'h00, 8'h00, 8'hFF));
        vecs.push_back(mk("read_in_reset",   1'b0, 2'b01, 8'hFF, 8'h00, 8'hA5));
        vecs.push_back(mk("a255_cleared",    1'b1, 2'b01, 8'hFF, 8'h00, 8'h00));
        vecs.push_back(mk("write_a5",        1'b1, 2'b10, 8'h05, 8'h11, 8'h00));
        vecs.push_back(mk("read_a5",         1'b1, 2'b01, 8'h05, 8'h00, 8'h11));
        vecs.push_back(mk("write_a0_again",  1'b1, 2'b10, 8'h00, 8'hFF, 8'h00));
        vecs.push_back(mk("reset_vs_write",  1'b0, 2'b10, 8'h05, 8'h3C, 8'h00));
        vecs.push_back(mk("post_rst_a0",     1'b1, 2'b01, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk("post_rst_a2",     1'b1, 2'b01, 8'h02, 8'h00, 8'h00));
        vecs.push_back(mk("post_rst_a5",     1'b1, 2'b01, 8'h05, 8'h00, 8'h00));
        vecs.push_back(mk("post_rst_a255",   1'b1, 2'b01, 8'hFF, 8'h00, 8'h00));

        foreach (vecs[i]) step(vecs[i]);

        // Combinational address sweep with no clock edge between reads.
        step(mk("sw_wr0",   1'b1, 2'b10, 8'h00, 8'h5A, 8'h00));
        step(mk("sw_wr2",   1'b1, 2'b10, 8'h02, 8'hC3, 8'h00));
        step(mk("sw_wr255", 1'b1, 2'b10, 8'hFF, 8'h81, 8'h00));
        drive(1'b1, 2'b01, 8'h00, 8'h00);
        #1 check("sweep_a0", DataOut, 8'h5A);
        DataAddress = 8'h02;
        #1 check("sweep_a2", DataOut, 8'hC3);
        DataAddress = 8'hFF;
        #1 check("sweep_a255", DataOut, 8'h81);
        MemStatus = 2'b00;
        #1 check("sweep_idle", DataOut, 8'h00);
        @(posedge CLK);
        #1;

        // Randomized traffic against the array model.
        step(mk("rand_reset", 1'b0, 2'b00, 8'h00, 8'h00, 8'h00));
        foreach (model[i]) model[i] = 8'h00;
        for (int n = 0; n < 400; n++) begin
            st  = 2'($urandom_range(0, 3));
            a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            d   = 8'($urandom);
            r   = ($urandom_range(0, 39) != 0);
            exp = (st == 2'b01) ? model[a] : 8'h00;
            step(mk($sformatf("rand%0d", n), r, st, a, d, exp));
            if (!r) begin
                foreach (model[i]) model[i] = 8'h00;
            end else if (st == 2'b10) begin
                model[a] = d;
            end
        end

        // Final full scan of the array.
        for (int i = 0; i < 256; i++) begin
            step(mk($sformatf("scan%0d", i), 1'b1, 2'b01, 8'(i), 8'h00, model[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
